// File: rtl/cordic_scale_arbiter.sv
// cordic_scale_arbiter: round-robin sharing of one combinational CORDIC
// gain-compensation scaler between N_REQ engines. One pair is granted in IDLE,
// scaled during the single SCALE cycle, and held in OUT until the consumer
// accepts it.
module cordic_scale_arbiter #(
   parameter  int CORDIC_WIDTH = 22,
   parameter  int N_REQ        = 4,
   localparam int ID_W         = $clog2(N_REQ)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [N_REQ-1:0]                 req_valid,
   output logic [N_REQ-1:0]                 req_ready,
   input  logic [N_REQ*CORDIC_WIDTH-1:0]    req_x,
   input  logic [N_REQ*CORDIC_WIDTH-1:0]    req_y,
   output logic                             scl_en,
   output logic signed [CORDIC_WIDTH-1:0]   scl_x_in,
   output logic signed [CORDIC_WIDTH-1:0]   scl_y_in,
   input  logic signed [CORDIC_WIDTH-1:0]   scl_x_out,
   input  logic signed [CORDIC_WIDTH-1:0]   scl_y_out,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic signed [CORDIC_WIDTH-1:0]   out_x,
   output logic signed [CORDIC_WIDTH-1:0]   out_y,
   output logic [ID_W-1:0]                  out_id,
   output logic                             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCALE = 2'd1,
      OUT   = 2'd2
   } state_t;

   state_t                         state_q, state_d;
   logic [ID_W-1:0]                last_grant_q, last_grant_d;
   logic [ID_W-1:0]                id_q, id_d;
   logic [ID_W-1:0]                out_id_q, out_id_d;
   logic signed [CORDIC_WIDTH-1:0] op_x_q, op_x_d;
   logic signed [CORDIC_WIDTH-1:0] op_y_q, op_y_d;
   logic signed [CORDIC_WIDTH-1:0] out_x_q, out_x_d;
   logic signed [CORDIC_WIDTH-1:0] out_y_q, out_y_d;

   logic                           grant_found;
   logic [ID_W-1:0]                grant_idx;
   logic [ID_W-1:0]                cand;
   int unsigned                    pos;
   logic [N_REQ-1:0]               grant_oh;
   logic signed [CORDIC_WIDTH-1:0] sel_x, sel_y;
   logic                           accept;

   // Rotating search: first valid requester at or after last_grant+1, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      pos         = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         pos = 32'(last_grant_q) + 32'd1 + i;
         if (pos >= N_REQ) pos = pos - N_REQ;
         cand = ID_W'(pos);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // One-hot grant and operand mux for the granted requester.
   always_comb begin
      grant_oh = '0;
      sel_x    = '0;
      sel_y    = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         grant_oh[i] = grant_found && (grant_idx == ID_W'(i));
         if (grant_oh[i]) begin
            sel_x = req_x[i*CORDIC_WIDTH +: CORDIC_WIDTH];
            sel_y = req_y[i*CORDIC_WIDTH +: CORDIC_WIDTH];
         end
      end
   end

   // Handshake and status outputs; all forced quiet while reset is held low.
   always_comb begin
      accept    = rst_n && (state_q == IDLE) && grant_found;
      req_ready = accept ? grant_oh : '0;
      scl_en    = rst_n && (state_q == SCALE);
      out_valid = rst_n && (state_q == OUT);
      busy      = rst_n && (state_q != IDLE);
      scl_x_in  = op_x_q;
      scl_y_in  = op_y_q;
      out_x     = out_x_q;
      out_y     = out_y_q;
      out_id    = out_id_q;
   end

   // Next-state and datapath register updates for IDLE -> SCALE -> OUT.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      op_x_d       = op_x_q;
      op_y_d       = op_y_q;
      out_x_d      = out_x_q;
      out_y_d      = out_y_q;
      out_id_d     = out_id_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_x_d       = sel_x;
               op_y_d       = sel_y;
               id_d         = grant_idx;
               last_grant_d = grant_idx;
               state_d      = SCALE;
            end
         end
         SCALE: begin
            out_x_d  = scl_x_out;
            out_y_d  = scl_y_out;
            out_id_d = id_q;
            state_d  = OUT;
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= ID_W'(N_REQ - 1);
         id_q         <= '0;
         op_x_q       <= '0;
         op_y_q       <= '0;
         out_x_q      <= '0;
         out_y_q      <= '0;
         out_id_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         op_x_q       <= op_x_d;
         op_y_q       <= op_y_d;
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
         out_id_q     <= out_id_d;
      end
   end

endmodule

// File: tb/tb_cordic_scale_arbiter.sv
// Directed bench for cordic_scale_arbiter with a shift-add scaler model
// (K = 1/2 + 1/8 - 1/64 - 1/512 - 1/4096 + 1/16384).
module tb_cordic_scale_arbiter;

   localparam int W = 22;
   localparam int N = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [N-1:0]          req_valid;
   logic [N-1:0]          req_ready;
   logic [N*W-1:0]        req_x, req_y;
   logic                  scl_en;
   logic signed [W-1:0]   scl_x_in, scl_y_in, scl_x_out, scl_y_out;
   logic                  out_valid, out_ready;
   logic signed [W-1:0]   out_x, out_y;
   logic [1:0]            out_id;
   logic                  busy;

   logic signed [W-1:0]   dx [N];
   logic signed [W-1:0]   dy [N];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   cordic_scale_arbiter #(.CORDIC_WIDTH(W), .N_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .scl_en(scl_en),
      .scl_x_in(scl_x_in), .scl_y_in(scl_y_in),
      .scl_x_out(scl_x_out), .scl_y_out(scl_y_out),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_id(out_id), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic signed [W-1:0] scale(input logic signed [W-1:0] v);
      return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 12) + (v >>> 14);
   endfunction

   // Scaler stand-in: combinational, zero when disabled.
   always_comb begin
      scl_x_out = scl_en ? scale(scl_x_in) : '0;
      scl_y_out = scl_en ? scale(scl_y_in) : '0;
   end

   task automatic pack();
      for (int i = 0; i < N; i++) begin
         req_x[i*W +: W] = dx[i];
         req_y[i*W +: W] = dy[i];
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req_valid = '0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = '1; out_ready = 1'b1;
      dx[0] = 22'sh012345; dy[0] = 22'sh054321;
      dx[1] = 22'sh023456; dy[1] = -22'sh011111;
      dx[2] = -22'sh034567; dy[2] = 22'sh022222;
      dx[3] = 22'sh0789AB; dy[3] = -22'sh033333;
      pack();
      @(negedge clk); @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (scl_en !== 1'b0) $display("FAIL reset_scl_en got %b want 0", scl_en); else n_pass++;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b want 0000", req_ready); else n_pass++;
      n_checks++; if (out_x !== 22'sd0 || out_y !== 22'sd0) $display("FAIL reset_out_xy got %h/%h want 0/0", out_x, out_y); else n_pass++;
      n_checks++; if (out_id !== 2'd0) $display("FAIL reset_out_id got %0d want 0", out_id); else n_pass++;
      n_checks++; if (scl_x_in !== 22'sd0) $display("FAIL reset_operand got %h want 0", scl_x_in); else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      dx[1] = 22'sh100000; dy[1] = -22'sh100000; pack();
      req_valid = 4'b0010; out_ready = 1'b1;
      #1;
      n_checks++; if (req_ready !== 4'b0010) $display("FAIL single_ready got %b want 0010", req_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_busy got %b want 0", busy); else n_pass++;
      @(negedge clk);
      req_valid = '0;
      n_checks++; if (scl_en !== 1'b1 || busy !== 1'b1) $display("FAIL single_scale got scl_en=%b busy=%b want 1 1", scl_en, busy); else n_pass++;
      n_checks++; if (scl_x_in !== 22'sh100000) $display("FAIL single_operand got %h want 100000", scl_x_in); else n_pass++;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL single_scale_ready got %b want 0000", req_ready); else n_pass++;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got %b want 1", out_valid); else n_pass++;
      n_checks++; if (out_x !== 22'sh09B740) $display("FAIL single_out_x got %h want 09b740", out_x); else n_pass++;
      n_checks++; if (out_y !== -22'sh09B740) $display("FAIL single_out_y got %h want %h", out_y, -22'sh09B740); else n_pass++;
      n_checks++; if (out_id !== 2'd1) $display("FAIL single_out_id got %0d want 1", out_id); else n_pass++;
      n_checks++; if (scl_en !== 1'b0) $display("FAIL single_out_scl_en got %b want 0", scl_en); else n_pass++;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_done got valid=%b busy=%b want 0 0", out_valid, busy); else n_pass++;
   endtask

   task automatic test_round_robin();
      int last_cyc = 0;
      do_reset();
      dx[0] = 22'sh040000; dy[0] = -22'sh020000;
      dx[1] = 22'sh0A1234; dy[1] = 22'sh015555;
      dx[2] = -22'sh1F0000; dy[2] = 22'sh1FFFFF;
      dx[3] = 22'sh000007; dy[3] = -22'sh200000;
      pack();
      req_valid = 4'b1111; out_ready = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         int exp = k % 4;
         int w = 0;
         while (req_ready == 4'b0000 && w < 8) begin @(negedge clk); w++; end
         n_checks++; if (req_ready !== 4'(1 << exp)) $display("FAIL rr_grant k=%0d got %b want id %0d", k, req_ready, exp); else n_pass++;
         if (k > 0) begin
            n_checks++; if (cyc - last_cyc !== 3) $display("FAIL rr_spacing k=%0d got %0d want 3", k, cyc - last_cyc); else n_pass++;
         end
         last_cyc = cyc;
         @(negedge clk);
         n_checks++; if (scl_en !== 1'b1 || scl_x_in !== dx[exp]) $display("FAIL rr_scale k=%0d got en=%b x=%h want 1 %h", k, scl_en, scl_x_in, dx[exp]); else n_pass++;
         @(negedge clk);
         n_checks++; if (out_valid !== 1'b1 || out_id !== 2'(exp)) $display("FAIL rr_out k=%0d got valid=%b id=%0d want 1 %0d", k, out_valid, out_id, exp); else n_pass++;
         n_checks++; if (out_x !== scale(dx[exp]) || out_y !== scale(dy[exp])) $display("FAIL rr_data k=%0d got %h/%h want %h/%h", k, out_x, out_y, scale(dx[exp]), scale(dy[exp])); else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_two_req();
      do_reset();
      req_valid = 4'b0101; out_ready = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         int exp = (k % 2) * 2;
         int w = 0;
         while (req_ready == 4'b0000 && w < 8) begin @(negedge clk); w++; end
         n_checks++; if (req_ready !== 4'(1 << exp)) $display("FAIL two_grant k=%0d got %b want id %0d", k, req_ready, exp); else n_pass++;
         @(negedge clk);
         @(negedge clk);
         n_checks++; if (out_id !== 2'(exp) || out_x !== scale(dx[exp])) $display("FAIL two_out k=%0d got id=%0d x=%h want %0d %h", k, out_id, out_x, exp, scale(dx[exp])); else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_back_pressure();
      int w = 0;
      do_reset();
      req_valid = 4'b0100; out_ready = 1'b0;
      #1;
      n_checks++; if (req_ready !== 4'b0100) $display("FAIL bp_grant got %b want 0100", req_ready); else n_pass++;
      @(negedge clk);
      req_valid = 4'b1111;
      while (out_valid !== 1'b1 && w < 8) begin @(negedge clk); w++; end
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_wait_valid got %b want 1", out_valid); else n_pass++;
      for (int c = 0; c < 10; c++) begin
         n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) $display("FAIL bp_hold c=%0d got valid=%b busy=%b want 1 1", c, out_valid, busy); else n_pass++;
         n_checks++; if (out_x !== scale(dx[2]) || out_y !== scale(dy[2]) || out_id !== 2'd2) $display("FAIL bp_data c=%0d got %h/%h id=%0d want %h/%h 2", c, out_x, out_y, out_id, scale(dx[2]), scale(dy[2])); else n_pass++;
         n_checks++; if (req_ready !== 4'b0000) $display("FAIL bp_ready c=%0d got %b want 0000", c, req_ready); else n_pass++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_release_valid got %b want 1", out_valid); else n_pass++;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_idle got valid=%b busy=%b want 0 0", out_valid, busy); else n_pass++;
      n_checks++; if (req_ready !== 4'b1000) $display("FAIL bp_next_grant got %b want 1000", req_ready); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 4'b0010; out_ready = 1'b1;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (out_x !== scale(dx[1])) $display("FAIL mid_first_result got %h want %h", out_x, scale(dx[1])); else n_pass++;
      req_valid = 4'b0100;
      #1;
      n_checks++; if (req_ready !== 4'b0100) $display("FAIL mid_grant got %b want 0100", req_ready); else n_pass++;
      @(negedge clk);
      n_checks++; if (scl_en !== 1'b1) $display("FAIL mid_in_scale got %b want 1", scl_en); else n_pass++;
      rst_n = 1'b0; req_valid = 4'b1111;
      #1;
      n_checks++; if (req_ready !== 4'b0000 || scl_en !== 1'b0 || busy !== 1'b0) $display("FAIL mid_rst_low got ready=%b en=%b busy=%b want 0000 0 0", req_ready, scl_en, busy); else n_pass++;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_after got valid=%b busy=%b want 0 0", out_valid, busy); else n_pass++;
      n_checks++; if (out_x !== 22'sd0 || out_y !== 22'sd0 || out_id !== 2'd0) $display("FAIL mid_cleared got %h/%h id=%0d want 0/0 0", out_x, out_y, out_id); else n_pass++;
      rst_n = 1'b1;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL mid_regrant got %b want 0001", req_ready); else n_pass++;
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_scl_en();
      int acc = 0, scl_cnt = 0, c = 0;
      logic prev_acc, prev_ov, prev_or;
      do_reset();
      req_valid = 4'b1111;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      prev_acc = (req_ready != 4'b0000);
      if (prev_acc) acc++;
      prev_ov = out_valid; prev_or = out_ready;
      while (scl_cnt < 100 && c < 2000) begin
         @(negedge clk);
         c++;
         n_checks++; if (scl_en !== prev_acc) $display("FAIL scl_en_cycle c=%0d got %b want %b", c, scl_en, prev_acc); else n_pass++;
         if (prev_ov && !prev_or) begin
            n_checks++; if (out_valid !== 1'b1) $display("FAIL scl_valid_drop c=%0d got %b want 1", c, out_valid); else n_pass++;
         end
         if (scl_en) scl_cnt++;
         if (acc >= 100) req_valid = '0;
         out_ready = 1'($urandom_range(0, 1));
         #1;
         prev_acc = (req_ready != 4'b0000);
         if (prev_acc) acc++;
         prev_ov = out_valid; prev_or = out_ready;
      end
      n_checks++; if (scl_cnt !== 100) $display("FAIL scl_en_count got %0d want 100", scl_cnt); else n_pass++;
      n_checks++; if (acc !== 100) $display("FAIL scl_accept_count got %0d want 100", acc); else n_pass++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      req_x = '0; req_y = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_two_req();
      test_back_pressure();
      test_reset_mid();
      test_scl_en();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cordic_scale_arbiter.md
# cordic_scale_arbiter

Round-robin arbiter and sequencer that shares one combinational CORDIC gain-compensation scaler (×≈0.60724, shift-add) between N_REQ CORDIC engines. Each engine offers an unscaled (x, y) pair with a valid/ready handshake. The block grants one engine at a time, drives the scaler's operands and enable, and registers the scaled result. It presents the result with the requester ID on a single valid/ready output port toward the downstream consumer.

## Interface
- CORDIC_WIDTH, 22, signed width of x/y operands and results
- N_REQ, 4, number of requesters, legal range 2..8; ID_W = $clog2(N_REQ)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  N_REQ  bit i: requester i offers a pair
- req_ready  out  N_REQ  bit i: requester i's pair is accepted this cycle
- req_x  in  N_REQ*CORDIC_WIDTH  signed x; requester i at [i*CORDIC_WIDTH +: CORDIC_WIDTH]
- req_y  in  N_REQ*CORDIC_WIDTH  signed y; same packing
- scl_en  out  1  scaler enable
- scl_x_in, scl_y_in  out  CORDIC_WIDTH  scaler operands
- scl_x_out, scl_y_out  in  CORDIC_WIDTH  scaler results; combinational from operands; zero when scl_en=0
- out_valid  out  1  scaled result available
- out_ready  in  1  downstream accepts the result
- out_x, out_y  out  CORDIC_WIDTH  registered scaled result
- out_id  out  ID_W  index of the requester that owns the result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SCALE, OUT.
- **IDLE**
  - The grant is combinational: the first set req_valid bit searched from ptr = (last_grant+1) mod N_REQ upward, wrapping.
  - req_ready is one-hot on the granted bit. It is all-zero if no bit is valid.
  - On valid&ready: capture the granted req_x/req_y into operand registers, capture the index into id_reg, set last_grant to the index, and go to SCALE.
- **SCALE**
  - scl_en=1. scl_x_in/scl_y_in are driven from the operand registers.
  - At the edge: out_x←scl_x_out, out_y←scl_y_out, out_id←id_reg, and go to OUT.
- **OUT**
  - out_valid=1. out_x, out_y and out_id are held stable.
  - On out_ready: go to IDLE.
- Outside SCALE, scl_en=0. scl_x_in/scl_y_in continue to show the operand registers; no zeroing is needed.
- req_ready is 0 in SCALE and OUT. Requesters hold their data while not accepted.
- No arithmetic is done in this block. Scaler results pass through at full CORDIC_WIDTH with no rounding or saturation.
- Fairness:
  - A requester that keeps req_valid high is granted within N_REQ grants.
  - last_grant updates only on an accepted transfer.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - State IDLE; last_grant = N_REQ-1, so the first search starts at requester 0.
  - Operand registers, out_x, out_y, out_id all 0.
  - out_valid=0, busy=0, scl_en=0, req_ready=0 while rst_n is low.
- Reset mid-operation, in SCALE or OUT, discards the in-flight pair and the result. No replay.
- Latency, with the accept at edge t:
  - SCALE occupies cycle t→t+1.
  - out_valid is high from after edge t+1.
  - With out_ready already high, the output handshake completes at edge t+2.
  - The next accept happens at edge t+3 at the earliest.
- Throughput is at most one pair per 3 cycles.
- out_ready low in OUT stalls indefinitely. Outputs stay stable and all req_ready stay 0.
- out_valid never drops without out_ready.
- Simultaneous valids are resolved by the rotating pointer only. There is no fixed priority except immediately after reset.
- req_valid deasserted before acceptance is legal and causes no grant. The pointer is unchanged.

## Test plan
- Single requester: reset, then req_valid[1]=1 with x=0x100000 and y=-0x100000.
  - Expect req_ready[1] at the accept cycle.
  - Expect out_valid 2 cycles later with out_x=0x09B740, out_y=-0x09B740 and out_id=1.
- All four valid continuously with distinct data, out_ready=1 → accepted IDs in order 0,1,2,3,0,…, each result matching its own scaled input, with 3-cycle spacing.
- Requesters 0 and 2 valid continuously → grants alternate 0,2,0,2. Requesters 1 and 3 never get req_ready.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - Expect out_x, out_y and out_id constant, all req_ready=0, and busy=1.
  - Raise out_ready → return to IDLE next edge.
- Reset asserted during SCALE → next cycle: out_valid=0, busy=0, outputs 0. The next grant goes to requester 0 if valid.
- scl_en check: scl_en=1 only in the single SCALE cycle of each transaction, counted over 100 random transactions with random out_ready.
